// File: rtl/gray_sobel_px_source_pkg.sv
// Shared definitions for the gray/sobel pixel-source stage.
//   DEF_PX_W   : pixel width fed to top_gray_sobel
//   DEF_LFSR_W : LFSR / seed / stop-code width (multiple of 8)
//   DEF_TAPS   : default Galois feedback mask
//   DEF_RATE_W : pacing interval width
//   DEF_CNT_W  : emitted-pixel counter width
//   gen_state_t: test-pattern generator states, also exported for debug
package gray_sobel_px_source_pkg;

  localparam int          DEF_PX_W   = 24;
  localparam int          DEF_LFSR_W = 16;
  localparam logic [15:0] DEF_TAPS   = 16'hB400;
  localparam int          DEF_RATE_W = 4;
  localparam int          DEF_CNT_W  = 20;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_RUN  = 2'd1,
    GEN_DONE = 2'd2
  } gen_state_t;

endpackage

// File: rtl/gray_sobel_px_source_if.sv
// Pixel stream bundle: a data word plus a one-cycle valid strobe.
//   px     : pixel data
//   px_rdy : px is valid this cycle
// Handshake semantics: there is no back-pressure. The master asserts px_rdy
// for exactly one cycle per pixel and the slave must take px in that cycle;
// px is only meaningful while px_rdy is high (the source stage additionally
// holds it stable between strobes).
interface gray_sobel_px_source_if
  import gray_sobel_px_source_pkg::*;
#(
  parameter int PX_W = DEF_PX_W
);
  logic [PX_W-1:0] px;
  logic            px_rdy;

  modport master (output px, output px_rdy);
  modport slave  (input  px, input  px_rdy);
endinterface

// File: rtl/gray_sobel_px_source_lfsr_galois.sv
// Galois LFSR used as test-pattern generator.
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   load_i          : load seed_i (a zero seed is replaced by 1, since the
//                     all-zero state would lock up)
//   seed_i          : seed value
//   step_i          : advance one position (ignored while load_i is high)
//   lfsr_o          : current LFSR state
module gray_sobel_px_source_lfsr_galois #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   TAPS = 16'hB400
) (
  input  logic         clk_i,
  input  logic         nreset_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic [W-1:0] lfsr_o
);

  logic [W-1:0] lfsr_q;
  logic [W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? W'(1) : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/gray_sobel_px_source.sv
// Pixel-source stage in front of top_gray_sobel. Chooses between the SPI
// pixel stream and an internal Galois LFSR test pattern. Seed and stop code
// are loaded byte-serially, MSB first (seed bytes, then stop-code bytes).
//   clk_i, nreset_i : clock, asynchronous active-low reset
//   select_input_i  : 0 = SPI path, 1 = LFSR path
//   cfg_byte_i      : configuration byte
//   cfg_valid_i     : cfg_byte_i valid strobe (ignored while running)
//   start_i         : launch an LFSR run
//   rate_i          : LFSR path emits one pixel every rate_i+1 cycles
//   spi_i           : pixel stream from spi_control (slave)
//   px_o            : pixel stream to top_gray_sobel (master)
//   cfg_done_o      : seed and stop code fully loaded
//   lfsr_busy_o     : generator running
//   lfsr_done_o     : generator reached the stop code
//   px_cnt_o        : pixels emitted by the current/last run, saturating
//   state_o         : generator state, for debug
module gray_sobel_px_source
  import gray_sobel_px_source_pkg::*;
#(
  parameter int                PX_W   = DEF_PX_W,
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter int                RATE_W = DEF_RATE_W,
  parameter int                CNT_W  = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  select_input_i,
  input  logic [7:0]            cfg_byte_i,
  input  logic                  cfg_valid_i,
  input  logic                  start_i,
  input  logic [RATE_W-1:0]     rate_i,
  gray_sobel_px_source_if.slave  spi_i,
  gray_sobel_px_source_if.master px_o,
  output logic                  cfg_done_o,
  output logic                  lfsr_busy_o,
  output logic                  lfsr_done_o,
  output logic [CNT_W-1:0]      px_cnt_o,
  output gen_state_t            state_o
);

  localparam int NB    = 2 * LFSR_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(NB / 2);

  // ---------------------------------------------------------------- state
  gen_state_t         state_q,     state_d;
  logic [IDX_W-1:0]   byte_idx_q,  byte_idx_d;
  logic [LFSR_W-1:0]  seed_q,      seed_d;
  logic [LFSR_W-1:0]  stop_q,      stop_d;
  logic               cfg_done_q,  cfg_done_d;
  logic [RATE_W-1:0]  rate_cap_q,  rate_cap_d;
  logic [RATE_W-1:0]  pace_q,      pace_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [PX_W-1:0]    px_q,        px_d;
  logic               px_rdy_q,    px_rdy_d;
  logic               busy_q;
  logic               done_q;

  logic               cfg_accept;
  logic               lfsr_load;
  logic               lfsr_step;
  logic               emit;
  logic [LFSR_W-1:0]  lfsr_w;
  logic [PX_W-1:0]    lfsr_px;

  gray_sobel_px_source_lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .load_i   (lfsr_load),
    .seed_i   (seed_q),
    .step_i   (lfsr_step),
    .lfsr_o   (lfsr_w)
  );

  // Pixel image of the LFSR: the LFSR word repeated from bit 0 upward,
  // truncated to the pixel width.
  always_comb begin
    lfsr_px = '0;
    for (int i = 0; i < PX_W; i++) begin
      lfsr_px[i] = lfsr_w[i % LFSR_W];
    end
  end

  // ---------------------------------------------------------------- loader
  // After a completed load the index is already back at 0, so a new byte
  // simply starts the next load and drops cfg_done.
  assign cfg_accept = cfg_valid_i && (state_q != GEN_RUN);

  always_comb begin
    byte_idx_d = byte_idx_q;
    seed_d     = seed_q;
    stop_d     = stop_q;
    cfg_done_d = cfg_done_q;
    if (cfg_accept) begin
      if (byte_idx_q < IDX_HALF) begin
        seed_d = (seed_q << 8) | LFSR_W'(cfg_byte_i);
      end else begin
        stop_d = (stop_q << 8) | LFSR_W'(cfg_byte_i);
      end
      if (byte_idx_q == IDX_LAST) begin
        byte_idx_d = '0;
        cfg_done_d = 1'b1;
      end else begin
        byte_idx_d = byte_idx_q + 1'b1;
        cfg_done_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- generator FSM
  always_comb begin
    state_d    = state_q;
    rate_cap_d = rate_cap_q;
    pace_d     = pace_q;
    cnt_d      = cnt_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    emit       = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        if (start_i && cfg_done_q && select_input_i) begin
          state_d    = GEN_RUN;
          lfsr_load  = 1'b1;
          pace_d     = '0;
          cnt_d      = '0;
          rate_cap_d = rate_i;
        end
      end
      GEN_RUN: begin
        if (!select_input_i) begin
          state_d = GEN_IDLE;
        end else if (pace_q == '0) begin
          // Current LFSR value goes out, then the LFSR advances.
          emit      = 1'b1;
          lfsr_step = 1'b1;
          pace_d    = rate_cap_q;
          cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (lfsr_w == stop_q) begin
            state_d = GEN_DONE;
          end
        end else begin
          pace_d = pace_q - 1'b1;
        end
      end
      GEN_DONE: begin
        if (!select_input_i || cfg_valid_i) begin
          state_d = GEN_IDLE;
        end else if (start_i) begin
          state_d    = GEN_RUN;
          lfsr_load  = 1'b1;
          pace_d     = '0;
          cnt_d      = '0;
          rate_cap_d = rate_i;
        end
      end
      default: begin
        state_d = GEN_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- output mux
  // SPI strobes only pass while the SPI path is selected; px holds between
  // strobes on either path.
  always_comb begin
    px_d     = px_q;
    px_rdy_d = 1'b0;
    if (!select_input_i) begin
      px_rdy_d = spi_i.px_rdy;
      if (spi_i.px_rdy) begin
        px_d = spi_i.px;
      end
    end else if (emit) begin
      px_rdy_d = 1'b1;
      px_d     = lfsr_px;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= GEN_IDLE;
      byte_idx_q <= '0;
      seed_q     <= '0;
      stop_q     <= '0;
      cfg_done_q <= 1'b0;
      rate_cap_q <= '0;
      pace_q     <= '0;
      cnt_q      <= '0;
      px_q       <= '0;
      px_rdy_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      seed_q     <= seed_d;
      stop_q     <= stop_d;
      cfg_done_q <= cfg_done_d;
      rate_cap_q <= rate_cap_d;
      pace_q     <= pace_d;
      cnt_q      <= cnt_d;
      px_q       <= px_d;
      px_rdy_q   <= px_rdy_d;
      busy_q     <= (state_d == GEN_RUN);
      done_q     <= (state_d == GEN_DONE);
    end
  end

  assign px_o.px     = px_q;
  assign px_o.px_rdy = px_rdy_q;
  assign cfg_done_o  = cfg_done_q;
  assign lfsr_busy_o = busy_q;
  assign lfsr_done_o = done_q;
  assign px_cnt_o    = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_gray_sobel_px_source.sv
// Directed bench for gray_sobel_px_source: reset, LFSR runs at two rates,
// zero seed, deselect/SPI path, ignored configuration and gated start.
module tb_gray_sobel_px_source;
  import gray_sobel_px_source_pkg::*;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  logic        select_input = 1'b0;
  logic [7:0]  cfg_byte     = 8'h00;
  logic        cfg_valid    = 1'b0;
  logic        start        = 1'b0;
  logic [3:0]  rate         = 4'd0;
  logic        cfg_done;
  logic        busy;
  logic        done;
  logic [19:0] cnt;
  gen_state_t  state;

  gray_sobel_px_source_if #(.PX_W(24)) spi_if ();
  gray_sobel_px_source_if #(.PX_W(24)) pix_if ();

  gray_sobel_px_source dut (
    .clk_i          (clk),
    .nreset_i       (nreset),
    .select_input_i (select_input),
    .cfg_byte_i     (cfg_byte),
    .cfg_valid_i    (cfg_valid),
    .start_i        (start),
    .rate_i         (rate),
    .spi_i          (spi_if.slave),
    .px_o           (pix_if.master),
    .cfg_done_o     (cfg_done),
    .lfsr_busy_o    (busy),
    .lfsr_done_o    (done),
    .px_cnt_o       (cnt),
    .state_o        (state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int          checks = 0;
  int          errors = 0;
  int          n_got;
  logic [23:0] got_px  [16];
  int          got_cyc [16];
  logic [23:0] exp_px  [3];

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_byte  = b;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] seed, input logic [15:0] stop);
    send_byte(seed[15:8]);
    send_byte(seed[7:0]);
    send_byte(stop[15:8]);
    send_byte(stop[7:0]);
  endtask

  task automatic start_run(input logic [3:0] r);
    rate  = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record strobed pixels until lfsr_done or the cycle budget runs out.
  // cfg_at >= 0 pulses cfg_valid (byte FF) on that cycle.
  task automatic capture(input int max_cyc, input int cfg_at);
    n_got = 0;
    for (int i = 0; i < 16; i++) begin
      got_px[i]  = 'x;
      got_cyc[i] = -100;
    end
    for (int c = 0; c < max_cyc; c++) begin
      cfg_byte  = 8'hFF;
      cfg_valid = (c == cfg_at);
      tick();
      cfg_valid = 1'b0;
      if (pix_if.px_rdy === 1'b1 && n_got < 16) begin
        got_px[n_got]  = pix_if.px;
        got_cyc[n_got] = c;
        n_got++;
      end
      if (done === 1'b1) break;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #1;
    checks++; if (pix_if.px !== 24'h0) begin errors++; $display("FAIL reset_px: got %h want 000000", pix_if.px); end
    checks++; if (pix_if.px_rdy !== 1'b0) begin errors++; $display("FAIL reset_px_rdy: got %b want 0", pix_if.px_rdy); end
    checks++; if (cnt !== 20'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", cnt); end
    checks++; if (state !== GEN_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    @(negedge clk);
    nreset = 1'b1;
    tick();
    select_input = 1'b1;
    load_cfg(16'hACE1, 16'h7138);
    start_run(4'd0);
    tick();
    checks++; if (pix_if.px_rdy !== 1'b1) begin errors++; $display("FAIL pre_reset_rdy: got %b want 1", pix_if.px_rdy); end
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (pix_if.px !== 24'h0) begin errors++; $display("FAIL async_reset_px: got %h want 000000", pix_if.px); end
    checks++; if (pix_if.px_rdy !== 1'b0) begin errors++; $display("FAIL async_reset_rdy: got %b want 0", pix_if.px_rdy); end
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL async_reset_cfg_done: got %b want 0", cfg_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_reset_done: got %b want 0", done); end
    checks++; if (cnt !== 20'h0) begin errors++; $display("FAIL async_reset_cnt: got %h want 0", cnt); end
    @(negedge clk);
    nreset = 1'b1;
    tick();
  endtask

  task automatic check_three(input string tag, input int gap);
    checks++; if (n_got !== 3) begin errors++; $display("FAIL %s_npix: got %0d want 3", tag, n_got); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_px[i] !== exp_px[i]) begin errors++; $display("FAIL %s_px%0d: got %h want %h", tag, i, got_px[i], exp_px[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] !== gap) begin errors++; $display("FAIL %s_gap%0d: got %0d want %0d", tag, i, got_cyc[i] - got_cyc[i-1], gap); end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
    checks++; if (cnt !== 20'd3) begin errors++; $display("FAIL %s_cnt: got %0d want 3", tag, cnt); end
  endtask

  task automatic test_basic_run();
    select_input = 1'b1;
    load_cfg(16'hACE1, 16'h7138);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL cfg_done: got %b want 1", cfg_done); end
    start_run(4'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b want 1", busy); end
    checks++; if (state !== GEN_RUN) begin errors++; $display("FAIL run_state: got %0d want 1", state); end
    capture(20, -1);
    check_three("basic", 1);
  endtask

  task automatic test_paced_run();
    start_run(4'd3);
    capture(40, -1);
    check_three("paced", 4);
  endtask

  task automatic test_zero_seed();
    load_cfg(16'h0000, 16'h0001);
    checks++; if (state !== GEN_IDLE) begin errors++; $display("FAIL zs_state_after_cfg: got %0d want 0", state); end
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL zs_cfg_done: got %b want 1", cfg_done); end
    start_run(4'd0);
    capture(20, -1);
    checks++; if (n_got !== 1) begin errors++; $display("FAIL zs_npix: got %0d want 1", n_got); end
    checks++; if (got_px[0] !== 24'h010001) begin errors++; $display("FAIL zs_px: got %h want 010001", got_px[0]); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zs_done: got %b want 1", done); end
    checks++; if (cnt !== 20'd1) begin errors++; $display("FAIL zs_cnt: got %0d want 1", cnt); end
  endtask

  task automatic test_deselect_spi();
    int extra;
    load_cfg(16'hACE1, 16'h7138);
    start_run(4'd0);
    tick();
    checks++; if (pix_if.px_rdy !== 1'b1) begin errors++; $display("FAIL ds_first_rdy: got %b want 1", pix_if.px_rdy); end
    select_input = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ds_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ds_done: got %b want 0", done); end
    checks++; if (state !== GEN_IDLE) begin errors++; $display("FAIL ds_state: got %0d want 0", state); end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (pix_if.px_rdy === 1'b1) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ds_extra_pix: got %0d want 0", extra); end
    spi_if.px     = 24'h123456;
    spi_if.px_rdy = 1'b1;
    tick();
    spi_if.px_rdy = 1'b0;
    checks++; if (pix_if.px_rdy !== 1'b1) begin errors++; $display("FAIL spi_rdy: got %b want 1", pix_if.px_rdy); end
    checks++; if (pix_if.px !== 24'h123456) begin errors++; $display("FAIL spi_px: got %h want 123456", pix_if.px); end
    tick();
    checks++; if (pix_if.px_rdy !== 1'b0) begin errors++; $display("FAIL spi_rdy_pulse: got %b want 0", pix_if.px_rdy); end
    checks++; if (pix_if.px !== 24'h123456) begin errors++; $display("FAIL spi_px_hold: got %h want 123456", pix_if.px); end
    select_input  = 1'b1;
    spi_if.px     = 24'h654321;
    spi_if.px_rdy = 1'b1;
    tick();
    spi_if.px_rdy = 1'b0;
    checks++; if (pix_if.px_rdy !== 1'b0) begin errors++; $display("FAIL spi_drop_rdy: got %b want 0", pix_if.px_rdy); end
    checks++; if (pix_if.px !== 24'h123456) begin errors++; $display("FAIL spi_drop_px: got %h want 123456", pix_if.px); end
  endtask

  task automatic test_cfg_ignored_and_gated_start();
    int extra;
    start_run(4'd1);
    capture(40, 1);
    check_three("cfgign", 2);
    checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL cfgign_cfg_done: got %b want 1", cfg_done); end
    send_byte(8'h11);
    checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL gate_cfg_done: got %b want 0", cfg_done); end
    checks++; if (state !== GEN_IDLE) begin errors++; $display("FAIL gate_state_cfg: got %0d want 0", state); end
    start_run(4'd0);
    checks++; if (state !== GEN_IDLE) begin errors++; $display("FAIL gate_state_start: got %0d want 0", state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_busy: got %b want 0", busy); end
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (pix_if.px_rdy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL gate_pix: got %0d want 0", extra); end
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    spi_if.px     = 24'h0;
    spi_if.px_rdy = 1'b0;
    exp_px[0] = 24'hE1ACE1;
    exp_px[1] = 24'h70E270;
    exp_px[2] = 24'h387138;
    test_reset();
    test_basic_run();
    test_paced_run();
    test_zero_seed();
    test_deselect_spi();
    test_cfg_ignored_and_gated_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
